mem16_word_port: RTL and testbench
==================================

MEM16_WORD_PORT -- requirements
Module: mem16_word_port

Interface
REQ-001 Ports SHALL be (clock and reset first); one clock, reset asynchronous and active-high:
 aclk  in  1  sole clock, rising edge
 areset  in  1  asynchronous active-high reset
 rx_req_valid  in  1  client request valid
 tx_req_ready  out  1  port accepts request
 rx_req_write  in  1  1=write, 0=read
 rx_req_byte  in  1  1=single byte access, 0=16-bit word
 rx_req_addr  in  16  byte address
 rx_req_wdata  in  16  write data; [7:0] only when byte=1
 tx_rsp_valid  out  1  response valid
 rx_rsp_ready  in  1  client accepts response
 tx_rsp_rdata  out  16  read data; 0 for writes and on error
 tx_rsp_error  out  1  access timed out
 tx_mem_enable  out  1  to memory16 rx_enable
 tx_mem_write  out  1  to memory16 rx_write
 tx_mem_strobe  out  1  to memory16 rx_strobe
 tx_mem_addr  out  16  to memory16 rx_program_counter
 tx_mem_wdata  out  8  to memory16 rx_data
 rx_mem_rdata  in  8  from memory16 tx_data
 rx_mem_ready  in  1  from memory16 tx_ready
REQ-002 All outputs SHALL be registered.

Function
REQ-003 FSM states SHALL be WARM, IDLE, LO_STB, LO_WAIT, HI_STB, HI_WAIT, RESP.
REQ-004 WARM SHALL last exactly 2 cycles after reset release, then enter IDLE; tx_mem_enable SHALL be 1 from the first cycle after reset release onward.
REQ-005 tx_req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with rx_req_valid & tx_req_ready, and the port SHALL latch write, byte, addr and wdata.
REQ-006 On accept the FSM SHALL enter LO_STB; LO_STB drives tx_mem_strobe=1 for exactly one cycle with tx_mem_addr=addr, tx_mem_write=write, tx_mem_wdata=wdata[7:0].
REQ-007 tx_mem_addr, tx_mem_write and tx_mem_wdata SHALL be valid from the LO_STB/HI_STB cycle and held stable until the matching WAIT state exits.
REQ-008 LO_WAIT SHALL exit on the first cycle with rx_mem_ready=1; for reads it captures rx_mem_rdata into rdata[7:0] on that cycle.
REQ-009 After LO_WAIT: byte access -> RESP; word access -> HI_STB.
REQ-010 HI_STB/HI_WAIT SHALL mirror LO_STB/LO_WAIT with tx_mem_addr=addr+1 (16-bit wrap, 0xFFFF->0x0000), tx_mem_wdata=wdata[15:8], capturing into rdata[15:8]; then -> RESP.
REQ-011 Byte order SHALL be little-endian; byte reads SHALL zero rdata[15:8].
REQ-012 Each WAIT state SHALL run a 4-bit watchdog cleared on entry; if 15 cycles elapse without rx_mem_ready, FSM SHALL enter RESP with tx_rsp_error=1, tx_rsp_rdata=0, skipping any remaining byte.
REQ-013 In RESP, tx_rsp_valid=1 with rdata/error stable until rx_rsp_ready=1; that cycle returns to IDLE; writes respond with rdata=0.
REQ-014 With memory16 timing (ready low 3 cycles after strobe), accept-to-tx_rsp_valid latency SHALL be 6 cycles for byte and 11 for word accesses.
REQ-015 tx_mem_strobe SHALL never assert while rx_mem_ready=0 or outside LO_STB/HI_STB.

Reset
REQ-016 While areset=1, regardless of state: FSM=WARM, tx_req_ready=0, tx_rsp_valid=0, tx_rsp_rdata=0, tx_rsp_error=0, tx_mem_enable=0, tx_mem_write=0, tx_mem_strobe=0, tx_mem_addr=0, tx_mem_wdata=0, watchdog=0.
REQ-017 Reset asserted mid-access SHALL abandon the access with no response; the next request is accepted only after WARM completes.

Verification
REQ-018 Reset release, rx_req_valid held 1 -> tx_req_ready first 1 on 3rd cycle after release; tx_mem_enable 1 from 1st.
REQ-019 Word write 0xBEEF to 0x1000, then word read 0x1000 -> rsp rdata=0xBEEF, error=0; memory bytes 0x1000=0xEF, 0x1001=0xBE; read rsp 11 cycles after accept.
REQ-020 Word read at 0xFFFF with bytes 0xFFFF=0x34, 0x0000=0x12 -> rdata=0x1234; second strobe addr=0x0000.
REQ-021 Byte read at 0x0042 holding 0xA5 -> rdata=0x00A5, single strobe, rsp 6 cycles after accept.
REQ-022 rx_mem_ready held 0 after LO_STB -> RESP after 15 wait cycles, error=1, rdata=0, no HI_STB.
REQ-023 rx_rsp_ready held 0 for 5 cycles -> rsp stable, tx_req_ready=0; areset pulsed during HI_WAIT -> all outputs reset immediately, no response.

Source files
------------

// File: rtl/mem16_word_port.sv
// Purpose: bridges 16-bit word/byte client requests onto a byte-wide memory16 strobe/ready port.
// Latency: accept to response valid is 6 cycles for bytes and 11 for words with a 3-cycle memory busy time.
// Backpressure: one request in flight; tx_req_ready only in IDLE while memory is ready, response held until rx_rsp_ready.
module mem16_word_port (
    input  logic        aclk,
    input  logic        areset,
    input  logic        rx_req_valid,
    output logic        tx_req_ready,
    input  logic        rx_req_write,
    input  logic        rx_req_byte,
    input  logic [15:0] rx_req_addr,
    input  logic [15:0] rx_req_wdata,
    output logic        tx_rsp_valid,
    input  logic        rx_rsp_ready,
    output logic [15:0] tx_rsp_rdata,
    output logic        tx_rsp_error,
    output logic        tx_mem_enable,
    output logic        tx_mem_write,
    output logic        tx_mem_strobe,
    output logic [15:0] tx_mem_addr,
    output logic [7:0]  tx_mem_wdata,
    input  logic [7:0]  rx_mem_rdata,
    input  logic        rx_mem_ready
);

    typedef enum logic [2:0] {
        WARM    = 3'd0,
        IDLE    = 3'd1,
        LO_STB  = 3'd2,
        LO_WAIT = 3'd3,
        HI_STB  = 3'd4,
        HI_WAIT = 3'd5,
        RESP    = 3'd6
    } state_t;

    // Watchdog gives up on the 15th consecutive wait cycle without ready.
    localparam logic [3:0] WDOG_LAST = 4'd14;

    state_t      state;
    logic [1:0]  warm_cnt;
    logic [3:0]  wdog;
    logic        req_write;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata_hi;

    // Access sequencer: every output is a register updated alongside the state.
    // tx_req_ready also tracks rx_mem_ready so a strobe is never issued into a busy memory
    // (e.g. one still finishing an access that the watchdog abandoned).
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= WARM;
            warm_cnt      <= 2'd0;
            wdog          <= 4'd0;
            req_write     <= 1'b0;
            req_byte      <= 1'b0;
            req_addr      <= 16'd0;
            req_wdata_hi  <= 8'd0;
            tx_req_ready  <= 1'b0;
            tx_rsp_valid  <= 1'b0;
            tx_rsp_rdata  <= 16'd0;
            tx_rsp_error  <= 1'b0;
            tx_mem_enable <= 1'b0;
            tx_mem_write  <= 1'b0;
            tx_mem_strobe <= 1'b0;
            tx_mem_addr   <= 16'd0;
            tx_mem_wdata  <= 8'd0;
        end else begin
            tx_mem_enable <= 1'b1;
            tx_mem_strobe <= 1'b0;
            case (state)
                WARM: begin
                    if (warm_cnt == 2'd2) begin
                        state        <= IDLE;
                        tx_req_ready <= rx_mem_ready;
                    end else begin
                        warm_cnt <= warm_cnt + 2'd1;
                    end
                end
                IDLE: begin
                    if (rx_req_valid && tx_req_ready) begin
                        state         <= LO_STB;
                        tx_req_ready  <= 1'b0;
                        req_write     <= rx_req_write;
                        req_byte      <= rx_req_byte;
                        req_addr      <= rx_req_addr;
                        req_wdata_hi  <= rx_req_wdata[15:8];
                        tx_mem_strobe <= 1'b1;
                        tx_mem_write  <= rx_req_write;
                        tx_mem_addr   <= rx_req_addr;
                        tx_mem_wdata  <= rx_req_wdata[7:0];
                        tx_rsp_rdata  <= 16'd0;
                        tx_rsp_error  <= 1'b0;
                    end else begin
                        tx_req_ready <= rx_mem_ready;
                    end
                end
                LO_STB: begin
                    state <= LO_WAIT;
                    wdog  <= 4'd0;
                end
                LO_WAIT: begin
                    if (rx_mem_ready) begin
                        if (!req_write) begin
                            tx_rsp_rdata[7:0] <= rx_mem_rdata;
                        end
                        if (req_byte) begin
                            state        <= RESP;
                            tx_rsp_valid <= 1'b1;
                        end else begin
                            state         <= HI_STB;
                            tx_mem_strobe <= 1'b1;
                            tx_mem_addr   <= req_addr + 16'd1;
                            tx_mem_wdata  <= req_wdata_hi;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        state        <= RESP;
                        tx_rsp_valid <= 1'b1;
                        tx_rsp_error <= 1'b1;
                        tx_rsp_rdata <= 16'd0;
                    end else begin
                        wdog <= wdog + 4'd1;
                    end
                end
                HI_STB: begin
                    state <= HI_WAIT;
                    wdog  <= 4'd0;
                end
                HI_WAIT: begin
                    if (rx_mem_ready) begin
                        if (!req_write) begin
                            tx_rsp_rdata[15:8] <= rx_mem_rdata;
                        end
                        state        <= RESP;
                        tx_rsp_valid <= 1'b1;
                    end else if (wdog == WDOG_LAST) begin
                        state        <= RESP;
                        tx_rsp_valid <= 1'b1;
                        tx_rsp_error <= 1'b1;
                        tx_rsp_rdata <= 16'd0;
                    end else begin
                        wdog <= wdog + 4'd1;
                    end
                end
                RESP: begin
                    if (rx_rsp_ready) begin
                        state        <= IDLE;
                        tx_rsp_valid <= 1'b0;
                        tx_req_ready <= rx_mem_ready;
                    end
                end
                default: begin
                    state <= WARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem16_word_port.sv
module tb_mem16_word_port;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        rx_req_valid = 1'b0;
    logic        tx_req_ready;
    logic        rx_req_write = 1'b0;
    logic        rx_req_byte = 1'b0;
    logic [15:0] rx_req_addr = 16'd0;
    logic [15:0] rx_req_wdata = 16'd0;
    logic        tx_rsp_valid;
    logic        rx_rsp_ready = 1'b1;
    logic [15:0] tx_rsp_rdata;
    logic        tx_rsp_error;
    logic        tx_mem_enable;
    logic        tx_mem_write;
    logic        tx_mem_strobe;
    logic [15:0] tx_mem_addr;
    logic [7:0]  tx_mem_wdata;
    logic [7:0]  rx_mem_rdata = 8'd0;
    logic        rx_mem_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    mem16_word_port dut (
        .aclk          (aclk),
        .areset        (areset),
        .rx_req_valid  (rx_req_valid),
        .tx_req_ready  (tx_req_ready),
        .rx_req_write  (rx_req_write),
        .rx_req_byte   (rx_req_byte),
        .rx_req_addr   (rx_req_addr),
        .rx_req_wdata  (rx_req_wdata),
        .tx_rsp_valid  (tx_rsp_valid),
        .rx_rsp_ready  (rx_rsp_ready),
        .tx_rsp_rdata  (tx_rsp_rdata),
        .tx_rsp_error  (tx_rsp_error),
        .tx_mem_enable (tx_mem_enable),
        .tx_mem_write  (tx_mem_write),
        .tx_mem_strobe (tx_mem_strobe),
        .tx_mem_addr   (tx_mem_addr),
        .tx_mem_wdata  (tx_mem_wdata),
        .rx_mem_rdata  (rx_mem_rdata),
        .rx_mem_ready  (rx_mem_ready)
    );

    always #5 aclk = ~aclk;

    // memory16 model: ready drops for 3 cycles after each strobe, stall freezes it low.
    logic [7:0]  mem [0:65535];
    logic [1:0]  mcnt = 2'd0;
    logic        mem_stall = 1'b0;
    int          strobe_cnt = 0;
    int          strobe_viol = 0;
    logic [15:0] last_strobe_addr = 16'd0;

    always @(posedge aclk) begin
        if (tx_mem_strobe && tx_mem_enable) begin
            if (!rx_mem_ready) strobe_viol <= strobe_viol + 1;
            if (tx_mem_write) mem[tx_mem_addr] <= tx_mem_wdata;
            rx_mem_rdata     <= mem[tx_mem_addr];
            rx_mem_ready     <= 1'b0;
            mcnt             <= 2'd2;
            strobe_cnt       <= strobe_cnt + 1;
            last_strobe_addr <= tx_mem_addr;
        end else if (!rx_mem_ready && !mem_stall) begin
            if (mcnt == 2'd0) rx_mem_ready <= 1'b1;
            else mcnt <= mcnt - 2'd1;
        end
    end

    typedef struct {
        logic        write;
        logic        byte_acc;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, tx_req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, tx_rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, {16'd0, tx_rsp_rdata}, 32'd0);
        chk({tag, "_rsp_error"}, {31'd0, tx_rsp_error}, 32'd0);
        chk({tag, "_mem_enable"}, {31'd0, tx_mem_enable}, 32'd0);
        chk({tag, "_mem_write"}, {31'd0, tx_mem_write}, 32'd0);
        chk({tag, "_mem_strobe"}, {31'd0, tx_mem_strobe}, 32'd0);
        chk({tag, "_mem_addr"}, {16'd0, tx_mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, {24'd0, tx_mem_wdata}, 32'd0);
    endtask

    // Presents a request and returns at the negedge of the first cycle after acceptance.
    task automatic send(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge aclk);
        rx_req_valid = 1'b1;
        rx_req_write = w;
        rx_req_byte  = b;
        rx_req_addr  = a;
        rx_req_wdata = d;
        while (!tx_req_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!tx_req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(negedge aclk);
        rx_req_valid = 1'b0;
    endtask

    // Cycles from the accept cycle to the first cycle with tx_rsp_valid (bounded).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!tx_rsp_valid && lat < 40) begin
            @(negedge aclk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int s0;
        logic [15:0] exp_last;

        vecs[0] = '{1'b1, 1'b0, 16'h1000, 16'hBEEF, 16'h0000, 1'b0, 11};
        vecs[1] = '{1'b0, 1'b0, 16'h1000, 16'h0000, 16'hBEEF, 1'b0, 11};
        vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 16'h1234, 16'h0000, 1'b0, 11};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 1'b0, 11};
        vecs[4] = '{1'b0, 1'b1, 16'h0042, 16'h0000, 16'h00A5, 1'b0, 6};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0012, 1'b0, 6};
        vecs[6] = '{1'b1, 1'b1, 16'h1001, 16'h5577, 16'h0000, 1'b0, 6};
        vecs[7] = '{1'b0, 1'b0, 16'h1000, 16'h0000, 16'h77EF, 1'b0, 11};
        vecs[8] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0034, 1'b0, 6};

        // Reset state, then warm-up with a byte write to 0x0042 pending throughout.
        rx_req_valid = 1'b1;
        rx_req_write = 1'b1;
        rx_req_byte  = 1'b1;
        rx_req_addr  = 16'h0042;
        rx_req_wdata = 16'hFFA5;
        @(negedge aclk);
        @(negedge aclk);
        chk_reset_outputs("por");
        areset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge aclk);
            chk($sformatf("warm_enable_c%0d", c), {31'd0, tx_mem_enable}, 32'd1);
            chk($sformatf("warm_req_ready_c%0d", c), {31'd0, tx_req_ready}, (c == 3) ? 32'd1 : 32'd0);
        end
        @(negedge aclk);
        rx_req_valid = 1'b0;
        wait_rsp(lat);
        chk("warm_write_lat", lat, 32'd6);
        chk("warm_write_err", {31'd0, tx_rsp_error}, 32'd0);
        @(negedge aclk);

        // Table-driven accesses.
        for (int i = 0; i <= 8; i++) begin
            s0 = strobe_cnt;
            send(vecs[i].write, vecs[i].byte_acc, vecs[i].addr, vecs[i].wdata);
            wait_rsp(lat);
            chk($sformatf("v%0d_rdata", i), {16'd0, tx_rsp_rdata}, {16'd0, vecs[i].exp_rdata});
            chk($sformatf("v%0d_error", i), {31'd0, tx_rsp_error}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_strobes", i), strobe_cnt - s0, vecs[i].byte_acc ? 32'd1 : 32'd2);
            exp_last = vecs[i].byte_acc ? vecs[i].addr : vecs[i].addr + 16'd1;
            chk($sformatf("v%0d_last_addr", i), {16'd0, last_strobe_addr}, {16'd0, exp_last});
            @(negedge aclk);
            chk($sformatf("v%0d_rsp_drop", i), {31'd0, tx_rsp_valid}, 32'd0);
        end
        chk("mem_1000", {24'd0, mem[16'h1000]}, 32'hEF);
        chk("mem_1001", {24'd0, mem[16'h1001]}, 32'h77);
        chk("mem_ffff", {24'd0, mem[16'hFFFF]}, 32'h34);
        chk("mem_0000", {24'd0, mem[16'h0000]}, 32'h12);

        // Watchdog: memory never returns ready after the low strobe.
        mem_stall = 1'b1;
        s0 = strobe_cnt;
        send(1'b0, 1'b0, 16'h1000, 16'h0000);
        wait_rsp(lat);
        chk("wdog_latency", lat, 32'd17);
        chk("wdog_error", {31'd0, tx_rsp_error}, 32'd1);
        chk("wdog_rdata", {16'd0, tx_rsp_rdata}, 32'd0);
        chk("wdog_strobes", strobe_cnt - s0, 32'd1);
        @(negedge aclk);
        mem_stall = 1'b0;
        repeat (5) @(negedge aclk);

        // Response backpressure: held response stays stable, no new request taken.
        rx_rsp_ready = 1'b0;
        send(1'b0, 1'b1, 16'h0042, 16'h0000);
        wait_rsp(lat);
        chk("bp_latency", lat, 32'd6);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), {31'd0, tx_rsp_valid}, 32'd1);
            chk($sformatf("bp_rdata_%0d", k), {16'd0, tx_rsp_rdata}, 32'h00A5);
            chk($sformatf("bp_req_ready_%0d", k), {31'd0, tx_req_ready}, 32'd0);
            @(negedge aclk);
        end
        rx_rsp_ready = 1'b1;
        @(negedge aclk);
        chk("bp_release", {31'd0, tx_rsp_valid}, 32'd0);

        // Reset during the high-byte wait abandons the access.
        s0 = strobe_cnt;
        send(1'b0, 1'b0, 16'h1000, 16'h0000);
        repeat (7) @(negedge aclk);
        chk("mid_strobes", strobe_cnt - s0, 32'd2);
        areset = 1'b1;
        #1;
        chk_reset_outputs("mid");
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge aclk);
            chk($sformatf("rewarm_rsp_valid_c%0d", c), {31'd0, tx_rsp_valid}, 32'd0);
            chk($sformatf("rewarm_req_ready_c%0d", c), {31'd0, tx_req_ready}, (c == 3) ? 32'd1 : 32'd0);
        end
        send(1'b0, 1'b0, 16'h1000, 16'h0000);
        wait_rsp(lat);
        chk("post_reset_rdata", {16'd0, tx_rsp_rdata}, 32'h77EF);
        chk("post_reset_latency", lat, 32'd11);
        @(negedge aclk);

        chk("strobe_while_busy", strobe_viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
